// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Register-file geometry shared by the writeback arbiter and users.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; first request at index >= ptr wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int               w_k;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    w_idx     = '0;
    for (int off = 0; off < N; off++) begin
      w_k = int'(ptr) + off;
      if (w_k >= N) w_k = w_k - N;
      w_idx = IDX_W'(w_k);
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin share of the register-file write port with pending-write scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REGS-1:0]       busy_mask
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_slot_full;
  logic [ADDR_W-1:0]  r_slot_addr [NUM_REQ];
  logic [DATA_W-1:0]  r_slot_data [NUM_REQ];
  logic [c_idx_w-1:0] r_ptr;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_accept;
  logic [c_idx_w-1:0] w_grant_idx;
  logic               w_any_grant;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (r_slot_full),
    .ptr       (r_ptr),
    .grant     (w_arb_grant),
    .grant_idx (w_grant_idx)
  );

  // A flush cycle issues nothing, so the pointer and slots see no grant.
  assign w_grant     = flush ? '0 : w_arb_grant;
  assign w_any_grant = |w_grant;
  assign req_ready   = (rst && !flush) ? (~r_slot_full | w_grant) : '0;
  assign w_accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst || flush) begin
        r_slot_full[i] <= 1'b0;
      end else if (w_accept[i] && (req_addr[i*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
        r_slot_full[i] <= 1'b1;
        r_slot_addr[i] <= req_addr[i*ADDR_W +: ADDR_W];
        r_slot_data[i] <= req_data[i*DATA_W +: DATA_W];
      end else if (w_grant[i]) begin
        r_slot_full[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (flush) begin
      r_wr_addr <= '0;
    end else if (w_any_grant) begin
      r_wr_addr <= r_slot_addr[w_grant_idx];
      r_wr_data <= r_slot_data[w_grant_idx];
      r_ptr     <= (w_grant_idx == c_idx_w'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    end else begin
      r_wr_addr <= '0;
    end
  end

  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  // Registers drop out of the mask once on wr_addr; the regfile bypass covers them.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_slot_full[i]) busy_mask = busy_mask | reg_onehot(r_slot_addr[i]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Directed self-checking bench for regfile_wb_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [31:0]               busy_mask;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i]                 = 1'b1;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;

    // Reset with every requester valid.
    tick();
    tick();
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wr_addr", 64'(wr_addr), 64'h0);
    check("rst_wr_data", 64'(wr_data), 64'h0);
    check("rst_busy", 64'(busy_mask), 64'h0);

    // Single write: two cycles from accept to wr_*.
    rst = 1'b1;
    req_valid = '0;
    tick();
    set_req(0, 5'd3, 32'hDEADBEEF);
    #1 check("single_ready", 64'(req_ready[0]), 64'h1);
    tick();
    req_valid = '0;
    check("single_c1_wr", 64'(wr_addr), 64'h0);
    check("single_c1_busy", 64'(busy_mask), 64'h8);
    tick();
    check("single_c2_wr", 64'(wr_addr), 64'h3);
    check("single_c2_data", 64'(wr_data), 64'hDEADBEEF);
    check("single_c2_busy", 64'(busy_mask), 64'h0);
    tick();
    check("single_c3_wr", 64'(wr_addr), 64'h0);

    // Three simultaneous requests from pointer 0.
    do_reset();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    set_req(2, 5'd4, 32'h44);
    tick();
    req_valid = '0;
    check("all3_busy", 64'(busy_mask), 64'h16);
    tick();
    check("all3_wr0", 64'(wr_addr), 64'h1);
    check("all3_data0", 64'(wr_data), 64'h11);
    tick();
    check("all3_wr1", 64'(wr_addr), 64'h2);
    tick();
    check("all3_wr2", 64'(wr_addr), 64'h4);
    check("all3_data2", 64'(wr_data), 64'h44);
    tick();
    check("all3_idle", 64'(wr_addr), 64'h0);

    // Continuous refill from all three: 1,2,4 repeating.
    req_valid = '1;
    tick();
    for (int n = 0; n < 6; n++) begin
      logic [ADDR_W-1:0] exp_a;
      tick();
      exp_a = (n % 3 == 0) ? 5'd1 : (n % 3 == 1) ? 5'd2 : 5'd4;
      check($sformatf("refill_%0d", n), 64'(wr_addr), 64'(exp_a));
    end
    req_valid = '0;

    // Address 0 is acknowledged but neither written nor advancing the pointer.
    do_reset();
    set_req(0, 5'd3, 32'h33);
    tick();
    req_valid = '0;
    tick();
    check("zero_pre_wr", 64'(wr_addr), 64'h3);
    set_req(1, 5'd0, 32'h12345678);
    #1 check("zero_ready", 64'(req_ready[1]), 64'h1);
    tick();
    req_valid = '0;
    check("zero_wr", 64'(wr_addr), 64'h0);
    check("zero_busy", 64'(busy_mask), 64'h0);
    tick();
    check("zero_wr_b", 64'(wr_addr), 64'h0);
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    set_req(2, 5'd4, 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("ptr_hold_0", 64'(wr_addr), 64'h2);
    tick();
    check("ptr_hold_1", 64'(wr_addr), 64'h4);
    tick();
    check("ptr_hold_2", 64'(wr_addr), 64'h1);

    // Back-to-back stream from requester 0.
    do_reset();
    set_req(0, 5'd5, 32'h5);
    #1 check("stream_rdy0", 64'(req_ready[0]), 64'h1);
    tick();
    set_req(0, 5'd6, 32'h6);
    #1 check("stream_rdy1", 64'(req_ready[0]), 64'h1);
    tick();
    check("stream_wr5", 64'(wr_addr), 64'h5);
    set_req(0, 5'd7, 32'h7);
    #1 check("stream_rdy2", 64'(req_ready[0]), 64'h1);
    tick();
    req_valid = '0;
    check("stream_wr6", 64'(wr_addr), 64'h6);
    tick();
    check("stream_wr7", 64'(wr_addr), 64'h7);
    check("stream_data7", 64'(wr_data), 64'h7);
    tick();
    check("stream_idle", 64'(wr_addr), 64'h0);

    // Flush drops pending slots and refuses new requests.
    do_reset();
    set_req(0, 5'd8, 32'h8);
    set_req(2, 5'd9, 32'h9);
    tick();
    req_valid = '0;
    check("flush_pre_busy", 64'(busy_mask), 64'h300);
    flush = 1'b1;
    set_req(1, 5'd12, 32'hC);
    #1 check("flush_ready", 64'(req_ready), 64'h0);
    tick();
    flush = 1'b0;
    req_valid = '0;
    check("flush_wr", 64'(wr_addr), 64'h0);
    check("flush_busy", 64'(busy_mask), 64'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("flush_after_%0d", n), 64'(wr_addr), 64'h0);
    end

    // Reset while a write is pending and another is on the port.
    do_reset();
    set_req(0, 5'd11, 32'hB);
    set_req(1, 5'd10, 32'hA);
    tick();
    req_valid = '0;
    tick();
    check("mid_wr11", 64'(wr_addr), 64'hB);
    check("mid_busy10", 64'(busy_mask), 64'h400);
    rst = 1'b0;
    #1 check("mid_rst_ready", 64'(req_ready), 64'h0);
    tick();
    check("mid_rst_wr", 64'(wr_addr), 64'h0);
    check("mid_rst_busy", 64'(busy_mask), 64'h0);
    rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check($sformatf("mid_after_%0d", n), 64'(wr_addr), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register file between several writeback producers, e.g. ALU, load unit and CP0/mult-div. Each requester has a 1-deep holding slot. Full slots are granted round-robin, and the winner is driven onto the registered write_addr/data_in pair that feeds the register file. The block also exports a pending-write scoreboard that hazard logic uses to stall readers.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset
flush  in  1  drop all pending writes (exception/squash)
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  destination register, requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  write data, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  slot can accept this cycle
wr_addr  out  ADDR_W  to register file write_addr; 0 = no write
wr_data  out  DATA_W  to register file data_in
busy_mask  out  32  bit r set = a write to register r is accepted but not yet on wr_addr

Behaviour:
- Reset (rst==0 at posedge):
  - all slots empty; RR pointer = 0
  - wr_addr = 0, wr_data = 0
  - busy_mask = 0
  - req_ready = 0 while rst is low
- Handshake:
  - accept[i] = req_valid[i] & req_ready[i]
  - req_ready[i] = !flush & (!slot_full[i] | grant[i])
  - a full slot that is being granted can accept a new request in the same cycle (back-to-back, 1 write per cycle per requester max)
  - req_addr/req_data are sampled only on accept
- Address 0:
  - an accepted request with addr 0 is acknowledged and discarded
  - the slot is not loaded and no port cycle is consumed
- Arbitration:
  - combinational, over full slots only
  - round-robin starting at pointer p; first full slot at index >= p (wrapping) wins
  - on a grant to i, p <= (i+1) mod NUM_REQ; with no grant, p holds
- Output stage:
  - at each posedge wr_addr/wr_data <= granted slot's addr/data, or wr_addr <= 0 when there is no grant
  - the granted slot empties at the same edge, unless it is refilled by a simultaneous accept
- Latency:
  - accept at edge E0 → slot full in cycle 1 → grant in cycle 1 (if uncontended) → wr_* valid in cycle 2
  - register file commits at the edge closing cycle 2
  - the register file's write bypass makes the value readable during cycle 2
- busy_mask:
  - combinational OR over full slots of a one-hot decode of the slot address
  - a register is clear once its write is on wr_addr, because bypass covers it
- Ordering:
  - writes from one requester commit in acceptance order
  - writes to the same register from different requesters commit in grant order
  - producers must check busy_mask to avoid WAW races
- Flush:
  - at the edge where flush==1, all slots empty and wr_addr <= 0
  - requests presented that cycle are not accepted (ready=0)
  - p holds
- Reset mid-operation: pending and in-flight writes are discarded; no partial write reaches the register file after the reset edge.
- Starvation bound: any full slot is granted within NUM_REQ cycles.

Decomposition:
- Shared package (regfile_pkg):
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32
  - REG_ZERO=5'd0
- One natural sub-module: rr_arbiter. Parameter N; inputs req[N] and ptr; outputs one-hot grant[N] and grant index.
- Slots, output register and scoreboard live in the top module.

Test Plan:
- Reset with all req_valid=1 → req_ready=0, wr_addr=0, busy_mask=0. After rst=1, a single req0 addr=3 data=32'hDEADBEEF → wr_addr=3, wr_data=DEADBEEF exactly 2 cycles after accept; busy_mask[3]=1 for 1 cycle.
- All 3 requesters valid in the same cycle (addrs 1,2,4) → wr_addr sequence 1,2,4 in consecutive cycles. A continuous refill of all three yields the repeating sequence 0,1,2 by requester index; no requester waits more than 3 cycles.
- req1 addr=0 data=32'h12345678 → req_ready=1, accepted; wr_addr stays 0; busy_mask stays 0; pointer unchanged.
- Requester 0 streams addrs 5,6,7 on back-to-back cycles while uncontended → accepted every cycle; wr_addr = 5,6,7 on consecutive cycles, in order.
- Slots 0 and 2 full (addrs 8, 9), flush=1 for one cycle with req1 valid → req_ready=0 that cycle; next cycle wr_addr=0 and busy_mask=0; addrs 8 and 9 are never written.
- rst asserted while slot 1 (addr 10) is pending and wr_addr=11 → after the reset edge wr_addr=0 and busy_mask=0; no write to 10 appears afterward.
